// File: rtl/lcd_pkg.sv
// Shared encodings and constants for the HD44780 command sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, EHI, HOLD, EXEC} state_e;

  typedef enum logic [2:0] {W250, W42, W100, W1640, W4100, W15000} wsel_e;

  localparam logic [7:0] CMD_FUNC_8BIT = 8'h38;
  localparam logic [7:0] CMD_OFF       = 8'h08;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_WAKE      = 8'h30;
  localparam int         INIT_LEN      = 8;

  typedef struct packed {
    logic [7:0] data;
    wsel_e      wsel;
  } init_ent_t;

  // Clear/home commands need the long 1.64 ms execution wait.
  function automatic wsel_e host_wait(input logic rs, input logic [7:0] data);
    return (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) ? W1640 : W42;
  endfunction

endpackage

// File: rtl/flag_mux.sv
// Selects the elapsed-time flag matching the current wait selector.
module flag_mux
  import lcd_pkg::*;
(
  input  wsel_e wsel,
  input  logic  flag_250ns,
  input  logic  flag_42us,
  input  logic  flag_100us,
  input  logic  flag_1640us,
  input  logic  flag_4100us,
  input  logic  flag_15000us,
  output logic  sel
);

  always_comb begin
    sel = 1'b0;
    case (wsel)
      W250:    sel = flag_250ns;
      W42:     sel = flag_42us;
      W100:    sel = flag_100us;
      W1640:   sel = flag_1640us;
      W4100:   sel = flag_4100us;
      W15000:  sel = flag_15000us;
      default: sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/lcd_init_rom.sv
// Power-up initialisation table: step -> command byte and post-command wait.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter logic [7:0] ENTRY_MODE   = 8'h06,
  parameter logic [7:0] DISPLAY_CTRL = 8'h0C
) (
  input  logic [2:0] step,
  output init_ent_t  ent
);

  always_comb begin
    ent = '{CMD_WAKE, W42};
    case (step)
      3'd0: ent = '{CMD_WAKE,      W4100};
      3'd1: ent = '{CMD_WAKE,      W100};
      3'd2: ent = '{CMD_WAKE,      W100};
      3'd3: ent = '{CMD_FUNC_8BIT, W42};
      3'd4: ent = '{CMD_OFF,       W42};
      3'd5: ent = '{CMD_CLEAR,     W1640};
      3'd6: ent = '{ENTRY_MODE,    W42};
      3'd7: ent = '{DISPLAY_CTRL,  W42};
      default: ent = '{CMD_WAKE, W42};
    endcase
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 sequencer: runs power-up init, then writes host bytes to the LCD bus
// using the external flag timer for every timed interval.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter logic [7:0] ENTRY_MODE   = 8'h06,
  parameter logic [7:0] DISPLAY_CTRL = 8'h0C,
  parameter int         SETUP_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  input  logic       flag_250ns,
  input  logic       flag_42us,
  input  logic       flag_100us,
  input  logic       flag_1640us,
  input  logic       flag_4100us,
  input  logic       flag_15000us,
  input  logic       flag_2s,
  output logic       flag_rst,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  localparam int SCW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  state_e         state;
  wsel_e          wsel;
  logic [3:0]     step;
  logic [SCW-1:0] sc;
  logic           blind;
  init_ent_t      rom_ent;
  logic           wait_flag;
  logic           flag_ok;
  logic           unused_flags;

  // Flags lag the restart by one cycle, so ignore them during and right after it.
  assign flag_ok      = ~flag_rst & ~blind;
  assign lcd_rw       = 1'b0;
  assign unused_flags = flag_2s;

  lcd_init_rom #(.ENTRY_MODE(ENTRY_MODE), .DISPLAY_CTRL(DISPLAY_CTRL)) u_rom (
    .step (step[2:0]),
    .ent  (rom_ent)
  );

  flag_mux u_mux (
    .wsel         (wsel),
    .flag_250ns   (flag_250ns),
    .flag_42us    (flag_42us),
    .flag_100us   (flag_100us),
    .flag_1640us  (flag_1640us),
    .flag_4100us  (flag_4100us),
    .flag_15000us (flag_15000us),
    .sel          (wait_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EXEC;
      wsel      <= W15000;
      step      <= '0;
      sc        <= '0;
      blind     <= 1'b0;
      flag_rst  <= 1'b1;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      in_ready  <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      flag_rst <= 1'b0;
      blind    <= flag_rst;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          lcd_rs   <= in_rs;
          lcd_data <= in_data;
          wsel     <= host_wait(in_rs, in_data);
          in_ready <= 1'b0;
          busy     <= 1'b1;
          sc       <= '0;
          state    <= SETUP;
        end
        SETUP: if (sc == SCW'(SETUP_CYC - 1)) begin
          lcd_e    <= 1'b1;
          flag_rst <= 1'b1;
          state    <= EHI;
        end else begin
          sc <= sc + 1'b1;
        end
        EHI: if (flag_250ns && flag_ok) begin
          lcd_e <= 1'b0;
          state <= HOLD;
        end
        HOLD: begin
          flag_rst <= 1'b1;
          state    <= EXEC;
        end
        EXEC: if (wait_flag && flag_ok) begin
          // step counts init bytes already issued; INIT_LEN means the table is done
          if (init_done || step == 4'(INIT_LEN)) begin
            init_done <= 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            lcd_rs   <= 1'b0;
            lcd_data <= rom_ent.data;
            wsel     <= rom_ent.wsel;
            step     <= step + 4'd1;
            sc       <= '0;
            state    <= SETUP;
          end
        end
        default: state <= EXEC;
      endcase
    end
  end

endmodule
